// File: rtl/alu_pkg.sv
// Shared ALU encodings: control codes, R-type funct values and ALUOp encodings.
package alu_pkg;

  localparam logic [2:0] CTL_AND = 3'b000;
  localparam logic [2:0] CTL_OR  = 3'b001;
  localparam logic [2:0] CTL_ADD = 3'b010;
  localparam logic [2:0] CTL_SLL = 3'b011;
  localparam logic [2:0] CTL_SUB = 3'b110;
  localparam logic [2:0] CTL_SLT = 3'b111;

  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpRtype = 2'b10,
    AluOpRsvd  = 2'b11
  } aluop_e;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational ALUOp/funct to ALU control decoder; flags unsupported encodings.
module alu_ctl_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] ctl,
  output logic       illegal
);

  always_comb begin
    ctl     = CTL_ADD;
    illegal = 1'b0;
    case (aluop_e'(aluop))
      AluOpAdd: ctl = CTL_ADD;
      AluOpSub: ctl = CTL_SUB;
      AluOpRtype: begin
        case (funct)
          FUNCT_ADD: ctl = CTL_ADD;
          FUNCT_SUB: ctl = CTL_SUB;
          FUNCT_AND: ctl = CTL_AND;
          FUNCT_OR:  ctl = CTL_OR;
          FUNCT_SLT: ctl = CTL_SLT;
          FUNCT_SLL: ctl = CTL_SLL;
          default:   illegal = 1'b1;
        endcase
      end
      AluOpRsvd: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register feeding the EX-stage ALU: decode, B select, forwarding, stall/flush.
// Define ALU_ISSUE_FWD_EN to enable EX/MEM and MEM/WB operand forwarding.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic          id_stall,
  input  logic          id_flush,
  input  logic [1:0]    id_aluop,
  input  logic          id_alusrc,
  input  logic          id_regdst,
  input  logic          id_regwrite,
  input  logic [31:0]   id_instr,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic          exm_regwrite,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_data,
  input  logic          mwb_regwrite,
  input  logic [RW-1:0] mwb_rd,
  input  logic [DW-1:0] mwb_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_ctl,
  output logic [4:0]    alu_shamt,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dest,
  output logic          ex_regwrite,
  output logic          ex_valid,
  output logic          ex_illegal
);

  logic [RW-1:0] rt_idx, rd_idx;
  logic [DW-1:0] imm_ext, rs_fwd, rt_fwd;
  logic [2:0]    dec_ctl;
  logic          dec_illegal;
  logic          unused_bits;

  assign rt_idx  = RW'(id_instr[20:16]);
  assign rd_idx  = RW'(id_instr[15:11]);
  assign imm_ext = {{(DW-16){id_instr[15]}}, id_instr[15:0]};

  alu_ctl_decode u_ctl_decode (
    .aluop   (id_aluop),
    .funct   (id_instr[5:0]),
    .ctl     (dec_ctl),
    .illegal (dec_illegal)
  );

`ifdef ALU_ISSUE_FWD_EN
  logic [RW-1:0] rs_idx;
  assign rs_idx = RW'(id_instr[25:21]);

  // EX/MEM is the younger result, so it is checked first; r0 never forwards.
  always_comb begin
    rs_fwd = id_rs_data;
    rt_fwd = id_rt_data;
    if (exm_regwrite && (exm_rd != '0) && (exm_rd == rs_idx)) begin
      rs_fwd = exm_data;
    end else if (mwb_regwrite && (mwb_rd != '0) && (mwb_rd == rs_idx)) begin
      rs_fwd = mwb_data;
    end
    if (exm_regwrite && (exm_rd != '0) && (exm_rd == rt_idx)) begin
      rt_fwd = exm_data;
    end else if (mwb_regwrite && (mwb_rd != '0) && (mwb_rd == rt_idx)) begin
      rt_fwd = mwb_data;
    end
  end

  assign unused_bits = ^id_instr[31:26];
`else
  assign rs_fwd = id_rs_data;
  assign rt_fwd = id_rt_data;

  // Forward ports stay wired at the top level but are ignored in this build.
  assign unused_bits = ^{id_instr[31:21], exm_regwrite, exm_rd, exm_data,
                         mwb_regwrite, mwb_rd, mwb_data};
`endif

  always_ff @(posedge clk) begin
    if (rst || id_flush || (!id_stall && !id_valid)) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_ctl       <= CTL_ADD;
      alu_shamt     <= '0;
      ex_store_data <= '0;
      ex_dest       <= '0;
      ex_regwrite   <= 1'b0;
      ex_valid      <= 1'b0;
      ex_illegal    <= 1'b0;
    end else if (!id_stall) begin
      alu_a         <= rs_fwd;
      alu_b         <= id_alusrc ? imm_ext : rt_fwd;
      alu_ctl       <= dec_ctl;
      alu_shamt     <= (dec_ctl == CTL_SLL) ? id_instr[10:6] : 5'd0;
      ex_store_data <= rt_fwd;
      ex_dest       <= id_regdst ? rd_idx : rt_idx;
      ex_regwrite   <= id_regwrite && !dec_illegal;
      ex_valid      <= 1'b1;
      ex_illegal    <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed vectors push expected outputs, a monitor checks.
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctl;
    logic [4:0]  shamt;
    logic [31:0] st;
    logic [4:0]  dest;
    logic        rw;
    logic        v;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_stall, id_flush, id_alusrc, id_regdst, id_regwrite;
  logic [1:0]  id_aluop;
  logic [31:0] id_instr, id_rs_data, id_rt_data;
  logic        exm_regwrite, mwb_regwrite;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_data, mwb_data;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [2:0]  alu_ctl;
  logic [4:0]  alu_shamt, ex_dest;
  logic        ex_regwrite, ex_valid, ex_illegal;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int vec = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_stall      (id_stall),
    .id_flush      (id_flush),
    .id_aluop      (id_aluop),
    .id_alusrc     (id_alusrc),
    .id_regdst     (id_regdst),
    .id_regwrite   (id_regwrite),
    .id_instr      (id_instr),
    .id_rs_data    (id_rs_data),
    .id_rt_data    (id_rt_data),
    .exm_regwrite  (exm_regwrite),
    .exm_rd        (exm_rd),
    .exm_data      (exm_data),
    .mwb_regwrite  (mwb_regwrite),
    .mwb_rd        (mwb_rd),
    .mwb_data      (mwb_data),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_ctl       (alu_ctl),
    .alu_shamt     (alu_shamt),
    .ex_store_data (ex_store_data),
    .ex_dest       (ex_dest),
    .ex_regwrite   (ex_regwrite),
    .ex_valid      (ex_valid),
    .ex_illegal    (ex_illegal)
  );

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] funct);
    return {6'h00, rs, rt, rd, sh, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {6'h08, rs, rt, imm};
  endfunction

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctl,
                              input logic [4:0] sh, input logic [31:0] st, input logic [4:0] dest,
                              input logic rw, input logic v, input logic ill);
    exp_t e;
    e = '{a: a, b: b, ctl: ctl, shamt: sh, st: st, dest: dest, rw: rw, v: v, ill: ill};
    return e;
  endfunction

  function automatic exp_t bubble();
    return mk(32'h0, 32'h0, 3'b010, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic clr();
    rst = 1'b0; id_valid = 1'b0; id_stall = 1'b0; id_flush = 1'b0;
    id_aluop = 2'b00; id_alusrc = 1'b0; id_regdst = 1'b0; id_regwrite = 1'b0;
    id_instr = 32'h0; id_rs_data = 32'h0; id_rt_data = 32'h0;
    exm_regwrite = 1'b0; exm_rd = 5'd0; exm_data = 32'h0;
    mwb_regwrite = 1'b0; mwb_rd = 5'd0; mwb_data = 32'h0;
  endtask

  // Inputs are set between negedges; the expected result is due just after the next posedge.
  task automatic cyc(input exp_t e);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic rtype_in(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
    clr();
    id_valid = 1'b1; id_aluop = 2'b10; id_regdst = 1'b1; id_regwrite = 1'b1;
    id_instr = instr; id_rs_data = rs; id_rt_data = rt;
  endtask

  initial begin : monitor
    exp_t e, g;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        g = mk(alu_a, alu_b, alu_ctl, alu_shamt, ex_store_data, ex_dest,
               ex_regwrite, ex_valid, ex_illegal);
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL vec%0d got a=%h b=%h ctl=%b sh=%0d st=%h dest=%0d rw=%b v=%b ill=%b | exp a=%h b=%h ctl=%b sh=%0d st=%h dest=%0d rw=%b v=%b ill=%b",
                   vec, g.a, g.b, g.ctl, g.shamt, g.st, g.dest, g.rw, g.v, g.ill,
                   e.a, e.b, e.ctl, e.shamt, e.st, e.dest, e.rw, e.v, e.ill);
        end
        vec++;
      end
    end
  end

  initial begin : stim
    clr();
    @(negedge clk);
    rst = 1'b1;
    cyc(bubble());                                                   // reset state

    rtype_in(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7);    // add
    cyc(mk(32'd5, 32'd7, 3'b010, 5'd0, 32'd7, 5'd3, 1'b1, 1'b1, 1'b0));

    rtype_in(rtype(5'd0, 5'd2, 5'd4, 5'd4, 6'h00), 32'd0, 32'd1);    // sll
    cyc(mk(32'd0, 32'd1, 3'b011, 5'd4, 32'd1, 5'd4, 1'b1, 1'b1, 1'b0));

    clr();                                                           // addi, negative imm
    id_valid = 1'b1; id_alusrc = 1'b1; id_regwrite = 1'b1;
    id_instr = itype(5'd1, 5'd5, 16'hFFFE); id_rs_data = 32'h10; id_rt_data = 32'h22;
    cyc(mk(32'h10, 32'hFFFF_FFFE, 3'b010, 5'd0, 32'h22, 5'd5, 1'b1, 1'b1, 1'b0));

    clr();                                                           // aluop sub, rt dest
    id_valid = 1'b1; id_aluop = 2'b01;
    id_instr = itype(5'd1, 5'd2, 16'h0003); id_rs_data = 32'd9; id_rt_data = 32'd4;
    cyc(mk(32'd9, 32'd4, 3'b110, 5'd0, 32'd4, 5'd2, 1'b0, 1'b1, 1'b0));

    rtype_in(rtype(5'd1, 5'd2, 5'd6, 5'd0, 6'h24), 32'hF0, 32'h3C);  // and
    cyc(mk(32'hF0, 32'h3C, 3'b000, 5'd0, 32'h3C, 5'd6, 1'b1, 1'b1, 1'b0));

    rtype_in(rtype(5'd1, 5'd2, 5'd7, 5'd0, 6'h25), 32'h1, 32'h2);    // or
    cyc(mk(32'h1, 32'h2, 3'b001, 5'd0, 32'h2, 5'd7, 1'b1, 1'b1, 1'b0));

    rtype_in(rtype(5'd7, 5'd8, 5'd9, 5'd0, 6'h2A), 32'h3, 32'h4);    // slt
    cyc(mk(32'h3, 32'h4, 3'b111, 5'd0, 32'h4, 5'd9, 1'b1, 1'b1, 1'b0));

    rtype_in(rtype(5'd1, 5'd2, 5'd8, 5'd0, 6'h22), 32'h30, 32'h10);  // funct sub
    cyc(mk(32'h30, 32'h10, 3'b110, 5'd0, 32'h10, 5'd8, 1'b1, 1'b1, 1'b0));

    rtype_in(rtype(5'd3, 5'd4, 5'd10, 5'd0, 6'h20), 32'h11, 32'h22); // both sources hit rs
    exm_regwrite = 1'b1; exm_rd = 5'd3; exm_data = 32'hAA;
    mwb_regwrite = 1'b1; mwb_rd = 5'd3; mwb_data = 32'hBB;
    cyc(mk(Fwd ? 32'hAA : 32'h11, 32'h22, 3'b010, 5'd0, 32'h22, 5'd10, 1'b1, 1'b1, 1'b0));

    exm_regwrite = 1'b0;                                             // only MEM/WB hits
    cyc(mk(Fwd ? 32'hBB : 32'h11, 32'h22, 3'b010, 5'd0, 32'h22, 5'd10, 1'b1, 1'b1, 1'b0));

    rtype_in(rtype(5'd0, 5'd4, 5'd10, 5'd0, 6'h20), 32'h55, 32'h22); // r0 never forwarded
    exm_regwrite = 1'b1; exm_rd = 5'd0; exm_data = 32'hAA;
    mwb_regwrite = 1'b1; mwb_rd = 5'd0; mwb_data = 32'hBB;
    cyc(mk(32'h55, 32'h22, 3'b010, 5'd0, 32'h22, 5'd10, 1'b1, 1'b1, 1'b0));

    clr();                                                           // rt forward into store only
    id_valid = 1'b1; id_alusrc = 1'b1;
    id_instr = itype(5'd0, 5'd4, 16'h0008); id_rs_data = 32'h1; id_rt_data = 32'h2;
    mwb_regwrite = 1'b1; mwb_rd = 5'd4; mwb_data = 32'hCC;
    cyc(mk(32'h1, 32'h8, 3'b010, 5'd0, Fwd ? 32'hCC : 32'h2, 5'd4, 1'b0, 1'b1, 1'b0));

    rtype_in(rtype(5'd1, 5'd2, 5'd11, 5'd0, 6'h25), 32'h1234, 32'h5678); // X
    cyc(mk(32'h1234, 32'h5678, 3'b001, 5'd0, 32'h5678, 5'd11, 1'b1, 1'b1, 1'b0));

    rtype_in(rtype(5'd1, 5'd2, 5'd12, 5'd0, 6'h22), 32'h9, 32'h8);   // stalled: X held
    id_stall = 1'b1;
    cyc(mk(32'h1234, 32'h5678, 3'b001, 5'd0, 32'h5678, 5'd11, 1'b1, 1'b1, 1'b0));
    id_rs_data = 32'hDEAD; id_instr = rtype(5'd1, 5'd2, 5'd13, 5'd3, 6'h00);
    cyc(mk(32'h1234, 32'h5678, 3'b001, 5'd0, 32'h5678, 5'd11, 1'b1, 1'b1, 1'b0));

    id_flush = 1'b1;                                                 // flush beats stall
    cyc(bubble());

    rtype_in(rtype(5'd1, 5'd2, 5'd14, 5'd0, 6'h3F), 32'h21, 32'h43); // illegal funct
    cyc(mk(32'h21, 32'h43, 3'b010, 5'd0, 32'h43, 5'd14, 1'b0, 1'b1, 1'b1));

    rtype_in(rtype(5'd1, 5'd2, 5'd15, 5'd7, 6'h00), 32'h5, 32'h6);   // aluop 11 reserved
    id_aluop = 2'b11;
    cyc(mk(32'h5, 32'h6, 3'b010, 5'd0, 32'h6, 5'd15, 1'b0, 1'b1, 1'b1));

    rtype_in(rtype(5'd1, 5'd2, 5'd16, 5'd0, 6'h20), 32'h7, 32'h8);   // invalid slot -> bubble
    id_valid = 1'b0;
    cyc(bubble());

    rtype_in(rtype(5'd1, 5'd2, 5'd17, 5'd2, 6'h00), 32'hA, 32'hB);   // load then reset+stall
    cyc(mk(32'hA, 32'hB, 3'b011, 5'd2, 32'hB, 5'd17, 1'b1, 1'b1, 1'b0));
    id_stall = 1'b1; rst = 1'b1;
    cyc(bubble());

    clr();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending expected 0 pending", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX boundary block that drives the 32-bit ALU's operand and control interface: A, B, 3-bit ctl, 5-bit shamt.
- Decodes ALUOp/funct into the ALU ctl code and selects B (register or sign-extended immediate).
- Resolves operand forwarding and registers everything into the ID/EX pipeline register, with stall and flush handling.
- Output feeds the EX-stage ALU directly; one-cycle latency.

Parameters:
- DW, 32, datapath width.
- RW, 5, register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  decode stage holds a real instruction.
- id_stall  in  1  hold ID/EX register (hazard unit).
- id_flush  in  1  insert bubble (branch taken).
- id_aluop  in  2  00 add, 01 sub, 10 R-type (use funct), 11 reserved.
- id_alusrc  in  1  1 selects immediate for B.
- id_regdst  in  1  1 selects rd, 0 selects rt as destination.
- id_regwrite  in  1  instruction writes the register file.
- id_instr  in  32  raw instruction: rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0].
- id_rs_data  in  DW  register-file read port 1.
- id_rt_data  in  DW  register-file read port 2.
- exm_regwrite, exm_rd, exm_data  in  1/RW/DW  forward source 1: EX/MEM result.
- mwb_regwrite, mwb_rd, mwb_data  in  1/RW/DW  forward source 2: MEM/WB result.
- alu_a  out  DW  ALU operand A.
- alu_b  out  DW  ALU operand B.
- alu_ctl  out  3  and 000, or 001, add 010, sll 011, sub 110, slt 111.
- alu_shamt  out  5  shift amount.
- ex_store_data  out  DW  forwarded rt value, used for sw.
- ex_dest  out  RW  destination register.
- ex_regwrite  out  1  write enable, qualified by valid.
- ex_valid  out  1  ID/EX slot is occupied.
- ex_illegal  out  1  unsupported funct or aluop 11.

Behaviour:
- Reset (rst=1 at posedge): all outputs 0, except alu_ctl=010. Reset overrides stall and flush.
- Register update priority: rst > id_flush > id_stall > load.
- Flush: load the bubble (ex_valid=0, ex_regwrite=0, ex_illegal=0, alu_ctl=010, all data 0), even if stall is also high.
- Stall: all outputs hold their value.
- Load: capture decoded values; ex_valid=id_valid. When id_valid=0, load the bubble.
- Latency: id_* inputs at edge N appear on outputs after edge N.
- ctl decode:
  - aluop 00 → 010.
  - aluop 01 → 110.
  - aluop 10, funct 0x20→010, 0x22→110, 0x24→000, 0x25→001, 0x2A→111, 0x00→011.
  - Any other funct, or aluop 11 → ctl 010, ex_illegal=1, ex_regwrite forced 0.
- shamt: instr[10:6] when ctl=011, else 0.
- Immediate: sign-extend imm[15:0] to DW.
- B select: alusrc=1 → immediate; else forwarded rt.
- dest: regdst ? rd : rt. ex_regwrite = id_regwrite & id_valid & !illegal.
- Forwarding (per operand, separately for rs and rt):
  - If exm_regwrite and exm_rd≠0 and exm_rd==src, use exm_data.
  - Else if the same holds for mwb, use mwb_data.
  - Else use register-file data.
  - EX/MEM wins when both match. Register 0 is never forwarded.
- ex_store_data always carries the forwarded rt, regardless of alusrc.
- Combinational paths only through the decode/forward logic into the register; outputs are pure flops.

Optional Feature:
- ALU_ISSUE_FWD_EN defined: forwarding as above.
- Undefined: exm_*/mwb_* inputs are ignored and operands come straight from the register file. Ports remain present so the top-level wiring is unchanged; the hazard unit must stall instead.

Decomposition:
- Shared package `alu_pkg` holds:
  - ALU ctl localparams: CTL_AND, CTL_OR, CTL_ADD, CTL_SLL, CTL_SUB, CTL_SLT.
  - funct constants.
  - ALUOp encodings.
- One natural sub-module, `alu_ctl_decode`: combinational aluop+funct → {ctl, illegal}. It is reusable by any future ALU variant.

Test Plan:
- R-type add: aluop=10, funct=0x20, rs_data=5, rt_data=7, no forwards → after 1 clk alu_ctl=010, alu_a=5, alu_b=7, ex_valid=1.
- sll: funct=0x00, shamt field=4, rt_data=0x1 → alu_ctl=011, alu_shamt=4. Then addi-style (aluop=00, alusrc=1, imm=0xFFFE) → alu_b=0xFFFFFFFE, alu_shamt=0.
- Forward priority: rs=3, exm_rd=3 data=0xAA, mwb_rd=3 data=0xBB, both regwrite=1 → alu_a=0xAA. Then exm_regwrite=0 → alu_a=0xBB. Then rs=0 with exm_rd=0 → alu_a=id_rs_data.
- Stall/flush: load instr X, assert id_stall 2 cycles with new inputs → outputs hold X. Assert stall+flush together → ex_valid=0, alu_ctl=010, data 0.
- Illegal: aluop=10, funct=0x3F, regwrite=1 → ex_illegal=1, ex_regwrite=0, alu_ctl=010.
- Reset mid-operation: valid instr loaded, rst=1 with stall=1 → next edge all outputs 0, alu_ctl=010.
